// File: rtl/sl_pkg.sv
// -----------------------------------------------------------------------------
// sl_pkg
// Shared definitions for the SL (two-wire, return-to-high) transmitter.
//   sl_state_t  : transmitter FSM state encoding (IDLE, LOAD, SEND, GAP)
//   SL_IDLE_LVL : level both SL lines rest at when no pulse is driven
//   odd_parity(): parity bit that makes the total count of ones odd
// -----------------------------------------------------------------------------
package sl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } sl_state_t;

  localparam logic SL_IDLE_LVL = 1'b1;

  // Returns 1 when data holds an even number of ones, so that data plus the
  // returned bit always carries an odd number of ones. Callers zero-extend
  // their word into the 64-bit argument; zero padding leaves parity unchanged.
  function automatic logic odd_parity(input logic [63:0] data);
    return ~(^data);
  endfunction

endpackage

// File: rtl/sl_bit_timer.sv
// -----------------------------------------------------------------------------
// sl_bit_timer
// Phase counter for one SL bit slot. Counts 0..BIT_PERIOD-1 while run is high
// and wraps, so consecutive slots (data slots and gap slots) follow each other
// with no dead cycle.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   clear         : force the phase back to 0 (has priority over run)
//   run           : advance the phase by one
//   pulse_active  : phase is inside the low part of the slot
//   slot_end      : phase is on the last cycle of the slot
// -----------------------------------------------------------------------------
module sl_bit_timer #(
  parameter int BIT_PERIOD  = 16,
  parameter int PULSE_WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic pulse_active,
  output logic slot_end
);

  localparam int PH_W = $clog2(BIT_PERIOD);

  logic [PH_W-1:0] phase_cnt;

  assign slot_end     = (phase_cnt == PH_W'(BIT_PERIOD - 1));
  assign pulse_active = (phase_cnt < PH_W'(PULSE_WIDTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt <= '0;
    end else if (clear) begin
      phase_cnt <= '0;
    end else if (run) begin
      phase_cnt <= slot_end ? '0 : phase_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sl_fifo_tx.sv
// -----------------------------------------------------------------------------
// sl_fifo_tx
// Read-side consumer of the async FIFO (runs on the FIFO read clock). Pops one
// word at a time and serialises it MSB first onto the SL line pair: a '1' is a
// low pulse on sl1, a '0' is a low pulse on sl0. Each word is followed by
// GAP_BITS idle slots with both lines high.
//
// Build option: define SL_TX_PARITY_EN to append an odd-parity slot after the
// data bits. Without it only the data bits are sent; the LOAD cycle remains so
// the pop-to-first-pulse latency is the same in both builds.
//
// Handshake: fifo_rd_inc is a single-cycle pop strobe, decoded only in IDLE as
// enable & ~fifo_rd_empty. The word on fifo_rd_data is taken on the same clock
// edge the strobe is high; the following LOAD cycle never pops, which gives the
// FIFO's registered empty flag time to settle.
//
// Ports:
//   clk            : clock (FIFO rd_clk)
//   rst_n          : asynchronous active-low reset
//   enable         : allows a new word to start (looked at only in IDLE)
//   fifo_rd_data   : FIFO head word
//   fifo_rd_empty  : FIFO empty flag
//   fifo_rd_inc    : FIFO pop strobe
//   sl0, sl1       : SL lines, idle high, registered
//   busy           : high in LOAD, SEND and GAP
//   state_dbg      : current FSM state (sl_state_t encoding)
// -----------------------------------------------------------------------------
module sl_fifo_tx
  import sl_pkg::*;
#(
  parameter int DATA_SIZE   = 8,
  parameter int BIT_PERIOD  = 16,
  parameter int PULSE_WIDTH = 8,
  parameter int GAP_BITS    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [DATA_SIZE-1:0] fifo_rd_data,
  input  logic                 fifo_rd_empty,
  output logic                 fifo_rd_inc,
  output logic                 sl0,
  output logic                 sl1,
  output logic                 busy,
  output logic [1:0]           state_dbg
);

`ifdef SL_TX_PARITY_EN
  localparam int NBITS = DATA_SIZE + 1;
`else
  localparam int NBITS = DATA_SIZE;
`endif

  // One counter serves as bit index in SEND and as slot index in GAP.
  localparam int CNT_MAX = (NBITS > GAP_BITS) ? NBITS : GAP_BITS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  sl_state_t        state;
  sl_state_t        state_nxt;
  logic [NBITS-1:0] shift_q;
  logic [CNT_W-1:0] bit_cnt;
  logic             sl0_q;
  logic             sl1_q;
  logic             sl0_nxt;
  logic             sl1_nxt;
  logic             pulse_active;
  logic             slot_end;
  logic             timer_clear;
  logic             timer_run;
  logic             last_slot;
  logic             gap_done;
  logic             cur_bit;

  // rst_n gating keeps the strobe low while reset is held, even though the
  // state register already reads IDLE during reset.
  assign fifo_rd_inc = rst_n & (state == ST_IDLE) & enable & ~fifo_rd_empty;
  assign busy        = (state != ST_IDLE);
  assign state_dbg   = state;
  assign sl0         = sl0_q;
  assign sl1         = sl1_q;

  assign cur_bit     = shift_q[NBITS-1];
  assign timer_clear = (state == ST_LOAD);
  assign timer_run   = (state == ST_SEND) || (state == ST_GAP);
  assign last_slot   = slot_end && (bit_cnt == CNT_W'(NBITS - 1));
  assign gap_done    = slot_end && (bit_cnt == CNT_W'(GAP_BITS - 1));

  sl_bit_timer #(
    .BIT_PERIOD  (BIT_PERIOD),
    .PULSE_WIDTH (PULSE_WIDTH)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (timer_clear),
    .run          (timer_run),
    .pulse_active (pulse_active),
    .slot_end     (slot_end)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (fifo_rd_inc) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_SEND;
      ST_SEND: if (last_slot) state_nxt = ST_GAP;
      ST_GAP:  if (gap_done) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Line levels are computed one cycle ahead and registered, so the first
  // pulse shows up two edges after the pop edge. Only the line matching the
  // current bit can be driven low, so both lines are never low together.
  always_comb begin
    sl0_nxt = SL_IDLE_LVL;
    sl1_nxt = SL_IDLE_LVL;
    if ((state == ST_SEND) && pulse_active) begin
      if (cur_bit) sl1_nxt = ~SL_IDLE_LVL;
      else         sl0_nxt = ~SL_IDLE_LVL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      shift_q <= '0;
      bit_cnt <= '0;
      sl0_q   <= SL_IDLE_LVL;
      sl1_q   <= SL_IDLE_LVL;
    end else begin
      state <= state_nxt;
      sl0_q <= sl0_nxt;
      sl1_q <= sl1_nxt;
      case (state)
        ST_IDLE: begin
          if (fifo_rd_inc) begin
`ifdef SL_TX_PARITY_EN
            // Data left-justified; the LSB slot is filled with parity in LOAD.
            shift_q <= {fifo_rd_data, 1'b0};
`else
            shift_q <= fifo_rd_data;
`endif
          end
        end
        ST_LOAD: begin
`ifdef SL_TX_PARITY_EN
          shift_q[0] <= odd_parity(64'(shift_q[NBITS-1:1]));
`endif
          bit_cnt <= '0;
        end
        ST_SEND: begin
          if (slot_end) begin
            shift_q <= {shift_q[NBITS-2:0], 1'b0};
            bit_cnt <= last_slot ? '0 : bit_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (slot_end) begin
            bit_cnt <= gap_done ? '0 : bit_cnt + 1'b1;
          end
        end
        default: begin
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sl_fifo_tx.sv
// -----------------------------------------------------------------------------
// tb_sl_fifo_tx
// Directed bench for sl_fifo_tx with default parameters. A queue models the
// FIFO read port; a line monitor decodes SL pulses and compares them against
// an expected-bit queue filled, at each pop, from hand-computed frame
// constants. Works in both builds (with or without SL_TX_PARITY_EN).
// -----------------------------------------------------------------------------
module tb_sl_fifo_tx;

  localparam int BP = 16;
  localparam int PW = 8;
  localparam int GB = 4;
`ifdef SL_TX_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  localparam int FRAME = 1 + NB * BP + GB * BP;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] fifo_rd_data = 8'h00;
  logic       fifo_rd_empty = 1'b1;
  logic       fifo_rd_inc;
  logic       sl0;
  logic       sl1;
  logic       busy;
  logic [1:0] state_dbg;

  initial forever #5 clk = ~clk;

  sl_fifo_tx dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_empty (fifo_rd_empty),
    .fifo_rd_inc   (fifo_rd_inc),
    .sl0           (sl0),
    .sl1           (sl1),
    .busy          (busy),
    .state_dbg     (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;

  logic [7:0] fifo_q[$];
  logic [8:0] frame_q[$];
  logic [0:0] exp_q[$];
  int         pop_hist[$];

  int   ncyc = 0;
  int   pop_cnt = 0;
  int   pop_n = 0;
  int   fall_cnt = 0;
  int   both_low_cnt = 0;
  int   low_len = 0;
  int   last_fall = 0;
  logic cur_line = 1'b0;
  logic prev0 = 1'b1;
  logic prev1 = 1'b1;
  logic [7:0] pop_word;
  logic [8:0] cur_frame;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // ---------------- FIFO read-port model ----------------
  always @(posedge clk) begin
    if (rst_n && fifo_rd_inc) begin
      check("pop_nonempty", fifo_q.size() > 0, 1);
      if (fifo_q.size() > 0) pop_word = fifo_q.pop_front();
      pop_cnt++;
      pop_n = ncyc;
      pop_hist.push_back(ncyc);
      check("frame_expected", frame_q.size() > 0, 1);
      if (frame_q.size() > 0) begin
        cur_frame = frame_q.pop_front();
        for (int i = NB - 1; i >= 0; i--) exp_q.push_back(cur_frame[i]);
      end
    end
    fifo_rd_empty <= (fifo_q.size() == 0);
    fifo_rd_data  <= (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  end

  // ---------------- SL line monitor ----------------
  always @(negedge clk) begin
    ncyc++;
    if (!rst_n) begin
      exp_q.delete();
      low_len = 0;
      prev0 = 1'b1;
      prev1 = 1'b1;
    end else begin
      if (!sl0 && !sl1) both_low_cnt++;
      if ((!sl0 && prev0) || (!sl1 && prev1)) begin
        fall_cnt++;
        cur_line = !sl1;
        // Pulse 0 appears three negedges after the negedge before the pop
        // edge, i.e. two clocks after the pop edge.
        if (exp_q.size() == NB) check("first_latency", ncyc - pop_n, 3);
        else check("slot_spacing", ncyc - last_fall, BP);
        last_fall = ncyc;
        low_len = 1;
      end else if (!sl0 || !sl1) begin
        low_len++;
      end else if (!prev0 || !prev1) begin
        check("pulse_width", low_len, PW);
        check("bits_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("pulse_line", cur_line, exp_q.pop_front());
      end
      prev0 = sl0;
      prev1 = sl1;
    end
  end

  // ---------------- driver tasks ----------------
  // f_par is the hand-computed 9-slot frame (data MSB first, odd parity last).
  task automatic push_word(input logic [7:0] w, input logic [8:0] f_par);
    fifo_q.push_back(w);
`ifdef SL_TX_PARITY_EN
    frame_q.push_back(f_par);
`else
    frame_q.push_back({1'b0, w});
`endif
  endtask

  task automatic wait_pop(input int old);
    int t;
    t = 0;
    while (pop_cnt == old && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("pop_seen", pop_cnt != old, 1);
  endtask

  // Waits (bounded) for busy, then counts negedges with busy high.
  task automatic run_frame(output int len, output int idle);
    len = 0;
    idle = 0;
    @(negedge clk);
    while (!busy && idle < 2000) begin
      @(negedge clk);
      idle++;
    end
    while (busy && len < 5000) begin
      len++;
      @(negedge clk);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int len, idle, p0, f0, pc, t;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_sl0", sl0, 1);
    check("rst_sl1", sl1, 1);
    check("rst_busy", busy, 0);
    check("rst_inc", fifo_rd_inc, 0);
    check("rst_state", state_dbg, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    enable = 1'b1;

    // 1: empty FIFO, enabled -> nothing happens
    repeat (500) @(negedge clk);
    check("t1_pops", pop_cnt, 0);
    check("t1_falls", fall_cnt, 0);
    check("t1_busy", busy, 0);
    check("t1_sl0", sl0, 1);
    check("t1_sl1", sl1, 1);

    // 2: single word 8'hA5 -> 1,0,1,0,0,1,0,1 (+ parity 1)
    #1;
    p0 = pop_cnt;
    f0 = fall_cnt;
    push_word(8'hA5, 9'h14B);
    run_frame(len, idle);
    check("t2_busy_len", len, FRAME);
    check("t2_pops", pop_cnt - p0, 1);
    check("t2_slots", fall_cnt - f0, NB);
    check("t2_bits_left", exp_q.size(), 0);

    // 3: 8'h00 then 8'hFF back-to-back
    #1;
    p0 = pop_cnt;
    f0 = fall_cnt;
    push_word(8'h00, 9'h001);
    push_word(8'hFF, 9'h1FF);
    run_frame(len, idle);
    check("t3_busy_len0", len, FRAME);
    run_frame(len, idle);
    check("t3_bubble", idle, 0);
    check("t3_busy_len1", len, FRAME);
    check("t3_pops", pop_cnt - p0, 2);
    // Next strobe is decoded in the first IDLE cycle, which begins FRAME
    // cycles after the previous pop edge; its pop edge ends that cycle.
    check("t3_pop_spacing", pop_hist[pop_hist.size()-1] - pop_hist[pop_hist.size()-2], FRAME + 1);
    check("t3_slots", fall_cnt - f0, 2 * NB);
    check("t3_bits_left", exp_q.size(), 0);

    // 4: enable dropped during bit 3 of 8'h3C, 8'h5A waiting
    #1;
    p0 = pop_cnt;
    f0 = fall_cnt;
    push_word(8'h3C, 9'h079);
    push_word(8'h5A, 9'h0B5);
    wait_pop(p0);
    repeat (1 + 3 * BP + 4) @(negedge clk);
    #1;
    enable = 1'b0;
    t = 0;
    while (busy && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("t4_frame_done", busy, 0);
    repeat (50) @(negedge clk);
    check("t4_pops", pop_cnt - p0, 1);
    check("t4_waiting", fifo_q.size(), 1);
    check("t4_slots", fall_cnt - f0, NB);
    check("t4_bits_left", exp_q.size(), 0);
    check("t4_idle_busy", busy, 0);
    #1;
    enable = 1'b1;
    #1;
    check("t4_reen_inc", fifo_rd_inc, 1);
    run_frame(len, idle);
    check("t4_reen_idle", idle, 0);
    check("t4_busy_len", len, FRAME);
    check("t4_pops2", pop_cnt - p0, 2);

    // 5: reset during bit 5 of 8'hC3 (bit 5 = 0 -> sl0 low), 8'h01 waiting
    #1;
    p0 = pop_cnt;
    push_word(8'hC3, 9'h187);
    push_word(8'h01, 9'h002);
    wait_pop(p0);
    repeat (5 * BP + 4) @(negedge clk);
    #1;
    check("t5_pre_rst_sl0", sl0, 0);
    rst_n = 1'b0;
    #1;
    check("t5_rst_sl0", sl0, 1);
    check("t5_rst_sl1", sl1, 1);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_inc", fifo_rd_inc, 0);
    pc = pop_cnt;
    repeat (5) @(negedge clk);
    check("t5_no_pop_in_rst", pop_cnt - pc, 0);
    #1;
    rst_n = 1'b1;
    run_frame(len, idle);
    check("t5_busy_len", len, FRAME);
    check("t5_pops", pop_cnt - p0, 2);
    check("t5_fifo_empty", fifo_q.size(), 0);
    check("t5_bits_left", exp_q.size(), 0);

    // 6: 8'h81 -> 1, six 0s, 1 (+ parity 1 when enabled)
    #1;
    f0 = fall_cnt;
    push_word(8'h81, 9'h103);
    run_frame(len, idle);
    check("t6_busy_len", len, FRAME);
    check("t6_slots", fall_cnt - f0, NB);
    check("t6_bits_left", exp_q.size(), 0);

    check("both_low", both_low_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
